// File: rtl/lcd_timed_ctrl.sv
// lcd_timed_ctrl
// Avalon-MM slave that runs HD44780-style LCD bus cycles with programmable
// setup / enable-high / hold timing. The CPU is stalled on waitrequest until
// the LCD cycle finishes, so the bus needs no extra wait-state setup.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   address[1:0]     [1] -> LCD_RS; [0] is not used (LCD_RW follows read/write)
//   read, write      Avalon strobes, held by the master while stalled
//   writedata[7:0]   byte sent to the LCD
//   readdata[7:0]    byte captured from the LCD, held until the next read
//   waitrequest      stall to the master; low for exactly one cycle per access
//   LCD_E/RS/RW      registered LCD control lines
//   LCD_data[7:0]    bidirectional LCD bus, released (Z) whenever not writing
//
// Parameters:
//   BUS_MODE         8 = single transfer, 4 = two nibbles on LCD_data[7:4]
//   SETUP_CYCLES     cycles RS/RW/data settle before E rises (>=1)
//   E_HIGH_CYCLES    cycles E is held high (>=1)
//   HOLD_CYCLES      cycles after E falls before the transfer ends (>=1)
module lcd_timed_ctrl #(
  parameter int BUS_MODE      = 8,
  parameter int SETUP_CYCLES  = 3,
  parameter int E_HIGH_CYCLES = 12,
  parameter int HOLD_CYCLES   = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int MAX_A   = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int MAX_CYC = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          nibble, nibble_d;
  logic          wr_op;
  logic [7:0]    wdata_q;
  logic          request;
  logic          setup_last, e_last, hold_last;
  logic          drive_en;
  logic [3:0]    hi_nib;
  logic          unused_addr0;

  assign unused_addr0 = address[0];
  assign request      = read | write;
  assign waitrequest  = request && (state != DONE);

  assign setup_last = (cnt == CW'(SETUP_CYCLES - 1));
  assign e_last     = (cnt == CW'(E_HIGH_CYCLES - 1));
  assign hold_last  = (cnt == CW'(HOLD_CYCLES - 1));

  // Next-state logic; each timed phase counts 0..N-1 and then hands over.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    nibble_d = nibble;
    case (state)
      IDLE: begin
        if (request) begin
          state_d  = SETUP;
          cnt_d    = '0;
          nibble_d = 1'b0;
        end
      end
      SETUP: begin
        if (setup_last) begin
          state_d = E_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      E_HIGH: begin
        if (e_last) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (hold_last) begin
          cnt_d = '0;
          // In 4-bit mode the first pass moves the high nibble; loop once more
          if ((BUS_MODE == 4) && !nibble) begin
            nibble_d = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the registered LCD control lines. LCD_E is derived
  // from the next state so it is a clean flop output aligned with E_HIGH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      nibble  <= 1'b0;
      wr_op   <= 1'b0;
      wdata_q <= 8'h00;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      LCD_RW  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      nibble <= nibble_d;
      LCD_E  <= (state_d == E_HIGH);
      if ((state == IDLE) && request) begin
        wr_op   <= write;
        wdata_q <= writedata;
        LCD_RS  <= address[1];
        LCD_RW  <= ~write;
      end
    end
  end

  // Read data is sampled on the last E-high cycle, while the LCD still drives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 8'h00;
    end else if ((state == E_HIGH) && e_last && !wr_op) begin
      if (BUS_MODE == 4) begin
        if (nibble) readdata[3:0] <= LCD_data[7:4];
        else        readdata[7:4] <= LCD_data[7:4];
      end else begin
        readdata <= LCD_data;
      end
    end
  end

  assign drive_en = wr_op && ((state == SETUP) || (state == E_HIGH) || (state == HOLD));
  assign hi_nib   = ((BUS_MODE == 4) && nibble) ? wdata_q[3:0] : wdata_q[7:4];

  assign LCD_data[7:4] = drive_en ? hi_nib : 4'bzzzz;
  assign LCD_data[3:0] = (drive_en && (BUS_MODE != 4)) ? wdata_q[3:0] : 4'bzzzz;

endmodule

// File: tb/tb_lcd_timed_ctrl.sv
// tb_lcd_timed_ctrl
// Directed self-checking bench. Three instances share clock and reset:
//   0: 8-bit default timing (with a small LCD model for reads)
//   1: 4-bit default timing
//   2: 8-bit with 1/1/1 timing for back-to-back accesses
// The LCD buses carry pullups, so a released bus reads as all ones.
module tb_lcd_timed_ctrl;

  logic       clk;
  logic       reset_n;
  logic [1:0] address [3];
  logic       rd      [3];
  logic       wr      [3];
  logic [7:0] wdata   [3];
  logic [7:0] rdata   [3];
  logic       wreq    [3];
  logic       lcd_e   [3];
  logic       lcd_rs  [3];
  logic       lcd_rw  [3];
  wire  [7:0] bus8;
  wire  [7:0] bus4;
  wire  [7:0] busf;

  int checks;
  int errors;

  int         r_done, r_ecnt, r_efirst, r_elast;
  logic [7:0] r_bus_e1, r_bus_e2, r_bus_c1, r_bus_done, r_rd_done;
  logic       r_rs1, r_rw1;
  logic [3:0] r_low_and;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (bus8[i]);
    pullup (bus4[i]);
    pullup (busf[i]);
  end

  // LCD model on instance 0: answers 0x80 while E is high during a read
  assign bus8 = (lcd_e[0] && lcd_rw[0]) ? 8'h80 : 8'bzzzzzzzz;

  lcd_timed_ctrl u_lcd8 (
    .clk(clk), .reset_n(reset_n), .address(address[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wdata[0]), .readdata(rdata[0]), .waitrequest(wreq[0]),
    .LCD_E(lcd_e[0]), .LCD_RS(lcd_rs[0]), .LCD_RW(lcd_rw[0]), .LCD_data(bus8)
  );

  lcd_timed_ctrl #(.BUS_MODE(4)) u_lcd4 (
    .clk(clk), .reset_n(reset_n), .address(address[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wdata[1]), .readdata(rdata[1]), .waitrequest(wreq[1]),
    .LCD_E(lcd_e[1]), .LCD_RS(lcd_rs[1]), .LCD_RW(lcd_rw[1]), .LCD_data(bus4)
  );

  lcd_timed_ctrl #(.SETUP_CYCLES(1), .E_HIGH_CYCLES(1), .HOLD_CYCLES(1)) u_lcdf (
    .clk(clk), .reset_n(reset_n), .address(address[2]), .read(rd[2]), .write(wr[2]),
    .writedata(wdata[2]), .readdata(rdata[2]), .waitrequest(wreq[2]),
    .LCD_E(lcd_e[2]), .LCD_RS(lcd_rs[2]), .LCD_RW(lcd_rw[2]), .LCD_data(busf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int inst, input bit w, input bit r, input logic [1:0] a, input logic [7:0] d);
    wr[inst]      = w;
    rd[inst]      = r;
    address[inst] = a;
    wdata[inst]   = d;
  endtask

  function automatic logic [7:0] busOf(input int inst);
    case (inst)
      0:       return bus8;
      1:       return bus4;
      default: return busf;
    endcase
  endfunction

  // Runs one access starting at the current cycle (called just after a
  // rising edge). Cycle 0 is the first request cycle; results land in r_*.
  // Returns just after the rising edge that ends the completion cycle.
  task automatic runTxn(input int inst, input bit w, input bit r, input logic [1:0] a,
                        input logic [7:0] d, input bit keep);
    logic       prev_e;
    logic [7:0] b;
    bit         fin;
    applyStimulus(inst, w, r, a, d);
    r_done = -1; r_ecnt = 0; r_efirst = -1; r_elast = -1;
    r_bus_e1 = 8'h00; r_bus_e2 = 8'h00; r_bus_c1 = 8'h00; r_bus_done = 8'h00;
    r_rd_done = 8'h00; r_rs1 = 1'b0; r_rw1 = 1'b0; r_low_and = 4'hF;
    prev_e = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      b = busOf(inst);
      r_low_and = r_low_and & b[3:0];
      if (lcd_e[inst] && !prev_e) begin
        r_ecnt++;
        if (r_ecnt == 1) begin
          r_efirst = cyc;
          r_bus_e1 = b;
        end else begin
          r_bus_e2 = b;
        end
      end
      if (lcd_e[inst]) r_elast = cyc;
      prev_e = lcd_e[inst];
      if (cyc == 1) begin
        r_bus_c1 = b;
        r_rs1    = lcd_rs[inst];
        r_rw1    = lcd_rw[inst];
      end
      if (!wreq[inst]) begin
        r_done     = cyc;
        r_bus_done = b;
        r_rd_done  = rdata[inst];
        fin        = 1'b1;
      end
    end
    if (!fin) checkOutput("txn_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) applyStimulus(inst, 1'b0, 1'b0, a, d);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 2'b00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset
    @(negedge clk);
    checkOutput("rst_e",    {31'd0, lcd_e[0]},  32'd0);
    checkOutput("rst_rs",   {31'd0, lcd_rs[0]}, 32'd0);
    checkOutput("rst_rw",   {31'd0, lcd_rw[0]}, 32'd0);
    checkOutput("rst_bus",  {24'd0, bus8},      32'hFF);
    checkOutput("rst_wreq", {31'd0, wreq[0]},   32'd0);
    checkOutput("rst_rd",   {24'd0, rdata[0]},  32'd0);
    @(posedge clk);
    #1;

    // 8-bit write 0x41 to address 2
    runTxn(0, 1'b1, 1'b0, 2'b10, 8'h41, 1'b0);
    checkOutput("w8_rs",      {31'd0, r_rs1},      32'd1);
    checkOutput("w8_rw",      {31'd0, r_rw1},      32'd0);
    checkOutput("w8_bus_c1",  {24'd0, r_bus_c1},   32'h41);
    checkOutput("w8_e_first", r_efirst,            32'd4);
    checkOutput("w8_e_last",  r_elast,             32'd15);
    checkOutput("w8_e_cnt",   r_ecnt,              32'd1);
    checkOutput("w8_done",    r_done,              32'd28);
    checkOutput("w8_bus_dn",  {24'd0, r_bus_done}, 32'hFF);

    // 8-bit read from address 1; LCD model returns 0x80
    runTxn(0, 1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    checkOutput("r8_rs",      {31'd0, r_rs1},      32'd0);
    checkOutput("r8_rw",      {31'd0, r_rw1},      32'd1);
    checkOutput("r8_bus_c1",  {24'd0, r_bus_c1},   32'hFF);
    checkOutput("r8_bus_e",   {24'd0, r_bus_e1},   32'h80);
    checkOutput("r8_done",    r_done,              32'd28);
    checkOutput("r8_rdata",   {24'd0, r_rd_done},  32'h80);
    checkOutput("r8_bus_dn",  {24'd0, r_bus_done}, 32'hFF);

    // 4-bit write 0x3C: two E pulses, high nibble first, low lines released
    runTxn(1, 1'b1, 1'b0, 2'b00, 8'h3C, 1'b0);
    checkOutput("w4_e_cnt",   r_ecnt,              32'd2);
    checkOutput("w4_e_first", r_efirst,            32'd4);
    checkOutput("w4_e_last",  r_elast,             32'd42);
    checkOutput("w4_bus_e1",  {24'd0, r_bus_e1},   32'h3F);
    checkOutput("w4_bus_e2",  {24'd0, r_bus_e2},   32'hCF);
    checkOutput("w4_low",     {28'd0, r_low_and},  32'hF);
    checkOutput("w4_done",    r_done,              32'd55);

    // 1/1/1 timing, back-to-back writes with request held through completion
    runTxn(2, 1'b1, 1'b0, 2'b00, 8'h01, 1'b1);
    checkOutput("bb1_done",   r_done,              32'd4);
    checkOutput("bb1_e_cnt",  r_ecnt,              32'd1);
    checkOutput("bb1_bus_e",  {24'd0, r_bus_e1},   32'h01);
    runTxn(2, 1'b1, 1'b0, 2'b00, 8'h02, 1'b0);
    checkOutput("bb2_done",   r_done,              32'd4);
    checkOutput("bb2_e_cnt",  r_ecnt,              32'd1);
    checkOutput("bb2_bus_e",  {24'd0, r_bus_e1},   32'h02);

    // Reset asserted while E is high on instance 0
    applyStimulus(0, 1'b1, 1'b0, 2'b00, 8'h55);
    repeat (6) @(negedge clk);
    checkOutput("mid_e_pre",  {31'd0, lcd_e[0]},   32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_e_rst",  {31'd0, lcd_e[0]},   32'd0);
    checkOutput("mid_bus",    {24'd0, bus8},       32'hFF);
    checkOutput("mid_rdata",  {24'd0, rdata[0]},   32'd0);
    applyStimulus(0, 1'b0, 1'b0, 2'b00, 8'h55);
    #1;
    checkOutput("mid_wreq",   {31'd0, wreq[0]},    32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    runTxn(0, 1'b1, 1'b0, 2'b00, 8'h55, 1'b0);
    checkOutput("post_done",  r_done,              32'd28);
    checkOutput("post_e_cnt", r_ecnt,              32'd1);
    checkOutput("post_bus",   {24'd0, r_bus_c1},   32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
